// File: rtl/sys_ctrl_pkg.sv
// Zed64 system controller: register map, ID and reset-sequencer states.
// Shared by sys_ctrl and sys_ctrl_irq.
package sys_ctrl_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_DIV    = 3'd1;
  localparam logic [2:0] REG_PEND   = 3'd2;
  localparam logic [2:0] REG_MASK   = 3'd3;
  localparam logic [2:0] REG_NMISEL = 3'd4;
  localparam logic [2:0] REG_ID     = 3'd5;

  localparam logic [7:0] SYS_ID = 8'h64;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_t;

endpackage

// File: rtl/sys_ctrl_irq.sv
// Interrupt edge capture, PEND/MASK/NMISEL and IRQ/NMI reduction.
// NMI routing exists only when SYS_CTRL_NMI_EN is defined.
module sys_ctrl_irq #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               wr_pend,
  input  logic               wr_mask,
  input  logic               wr_nmisel,
  input  logic [NUM_IRQ-1:0] wdata,
  output logic [NUM_IRQ-1:0] pend,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] nmisel,
  output logic               irq_n,
  output logic               nmi_n
);

  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  assign rise = irq_src & ~src_q;
  assign clr  = wr_pend ? wdata : '0;

  // src_q tracks the sources even in reset so a level held
  // through reset does not look like a fresh edge
  always_ff @(posedge clk) begin
    src_q <= irq_src;
    if (reset) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~clr) | rise;
      if (wr_mask)
        mask <= wdata;
    end
  end

`ifdef SYS_CTRL_NMI_EN
  always_ff @(posedge clk) begin
    if (reset)
      nmisel <= '0;
    else if (wr_nmisel)
      nmisel <= wdata;
  end

  assign irq_n = ~|(pend & mask & ~nmisel);
  assign nmi_n = ~|(pend & nmisel);
`else
  logic nmi_unused;

  assign nmi_unused = wr_nmisel;
  assign nmisel     = '0;
  assign irq_n      = ~|(pend & mask);
  assign nmi_n      = 1'b1;
`endif

endmodule

// File: rtl/sys_ctrl.sv
// Zed64 system controller: clock-enable divider, CPU reset sequencer, bus regs.
// Define SYS_CTRL_NMI_EN to enable NMISEL routing to cpu_nmi_n.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int                    NUM_IRQ     = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'hFFE0,
  parameter int                    RST_STRETCH = 16,
  parameter logic [7:0]            DIV_RESET   = 8'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_locked,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [7:0]            bus_wdata,
  input  logic                  bus_we,
  input  logic                  bus_cyc,
  output logic                  bus_hit,
  output logic [7:0]            bus_rdata,
  input  logic [NUM_IRQ-1:0]    irq_src,
  output logic                  cpu_ce,
  output logic                  cpu_reset,
  output logic                  cpu_irq_n,
  output logic                  cpu_nmi_n,
  output logic                  cpu_rdy
);

  localparam int RW = $clog2(RST_STRETCH) + 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_STRETCH - 1);

  logic [2:0]         off;
  logic               access;
  logic               wr;
  logic               rd;
  logic               wr_ctrl;
  logic               wr_div;
  logic               srst;
  logic [7:0]         div;
  logic [7:0]         div_cnt;
  logic [RW-1:0]      rst_cnt;
  rst_state_t         state;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] nmisel;
  logic [7:0]         rmux;

  assign off     = bus_addr[2:0];
  assign bus_hit = bus_addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3];
  assign access  = bus_cyc & bus_hit & cpu_ce;
  assign wr      = access & bus_we;
  assign rd      = access & ~bus_we;
  assign wr_ctrl = wr && (off == REG_CTRL);
  assign wr_div  = wr && (off == REG_DIV);
  assign srst    = wr_ctrl & bus_wdata[1];

  // cpu_ce is registered, so it trails the terminal count by a cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= DIV_RESET;
      div_cnt <= '0;
      cpu_ce  <= 1'b0;
    end else begin
      cpu_ce <= (div_cnt == div);
      if (wr_div) begin
        div     <= bus_wdata;
        div_cnt <= '0;
      end else if (div_cnt == div) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !clk_locked || srst) begin
      state     <= ST_HOLD;
      rst_cnt   <= '0;
      cpu_reset <= 1'b1;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        ST_RUN: cpu_reset <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cpu_rdy <= 1'b1;
    else if (wr_ctrl)
      cpu_rdy <= bus_wdata[0];
  end

  sys_ctrl_irq #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .wr_pend   (wr && (off == REG_PEND)),
    .wr_mask   (wr && (off == REG_MASK)),
    .wr_nmisel (wr && (off == REG_NMISEL)),
    .wdata     (bus_wdata[NUM_IRQ-1:0]),
    .pend      (pend),
    .mask      (mask),
    .nmisel    (nmisel),
    .irq_n     (cpu_irq_n),
    .nmi_n     (cpu_nmi_n)
  );

  always_comb begin
    rmux = '0;
    case (off)
      REG_CTRL:   rmux = {7'd0, cpu_rdy};
      REG_DIV:    rmux = div;
      REG_PEND:   rmux = 8'(pend);
      REG_MASK:   rmux = 8'(mask);
      REG_NMISEL: rmux = 8'(nmisel);
      REG_ID:     rmux = SYS_ID;
      default:    rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus_rdata <= '0;
    else if (rd)
      bus_rdata <= rmux;
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl; NMI expectations follow SYS_CTRL_NMI_EN.
module tb_sys_ctrl;

  localparam logic [15:0] BASE = 16'hFFE0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_locked = 1'b1;
  logic [15:0] bus_addr = BASE;
  logic [7:0]  bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_cyc = 1'b0;
  logic        bus_hit;
  logic [7:0]  bus_rdata;
  logic [7:0]  irq_src = '0;
  logic        cpu_ce;
  logic        cpu_reset;
  logic        cpu_irq_n;
  logic        cpu_nmi_n;
  logic        cpu_rdy;

  int vectors = 0;
  int miscompares = 0;
  int n;
  logic [7:0] d;

  sys_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .clk_locked (clk_locked),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_cyc    (bus_cyc),
    .bus_hit    (bus_hit),
    .bus_rdata  (bus_rdata),
    .irq_src    (irq_src),
    .cpu_ce     (cpu_ce),
    .cpu_reset  (cpu_reset),
    .cpu_irq_n  (cpu_irq_n),
    .cpu_nmi_n  (cpu_nmi_n),
    .cpu_rdy    (cpu_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ce;
    int k;
    k = 0;
    while (cpu_ce !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    if (cpu_ce !== 1'b1) begin
      miscompares++;
      $error("FAIL ce_timeout: observed %b expected 1", cpu_ce);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] wd);
    wait_ce();
    bus_addr  = BASE | {13'd0, off};
    bus_wdata = wd;
    bus_we    = 1'b1;
    bus_cyc   = 1'b1;
    tick();
    bus_cyc   = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [7:0] rd);
    wait_ce();
    bus_addr = BASE | {13'd0, off};
    bus_we   = 1'b0;
    bus_cyc  = 1'b1;
    tick();
    bus_cyc  = 1'b0;
    rd       = bus_rdata;
  endtask

  task automatic ticks_to_ce(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (cpu_ce !== 1'b1 && cnt < 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_irq_n", cpu_irq_n, 1);
    check("rst_nmi_n", cpu_nmi_n, 1);
    check("rst_rdy", cpu_rdy, 1);

    // release reset; divider 1 gives a pulse every other cycle
    reset = 1'b0;
    tick();
    check("c1_ce", cpu_ce, 0);
    check("c1_cpu_reset", cpu_reset, 1);
    tick();
    check("c2_ce", cpu_ce, 1);
    tick();
    check("c3_ce", cpu_ce, 0);
    tick();
    check("c4_ce", cpu_ce, 1);
    repeat (11) tick();
    check("c15_cpu_reset", cpu_reset, 1);
    tick();
    check("c16_cpu_reset", cpu_reset, 0);

    bus_addr = 16'h1005;
    #1 check("hit_out", bus_hit, 0);
    bus_addr = 16'hFFE5;
    #1 check("hit_in", bus_hit, 1);
    bus_addr = 16'hFFD7;
    #1 check("hit_below", bus_hit, 0);

    bus_read(3'd5, d);
    check("rd_id", d, 8'h64);
    bus_read(3'd6, d);
    check("rd_off6", d, 8'h00);
    bus_read(3'd0, d);
    check("rd_ctrl", d, 8'h01);
    bus_read(3'd1, d);
    check("rd_div", d, 8'h01);

    // write while cpu_ce is low must be dropped
    wait_ce();
    tick();
    check("ce_low", cpu_ce, 0);
    bus_addr  = BASE | 16'd3;
    bus_wdata = 8'hFF;
    bus_we    = 1'b1;
    bus_cyc   = 1'b1;
    tick();
    bus_cyc   = 1'b0;
    bus_we    = 1'b0;
    bus_read(3'd3, d);
    check("ce_low_ignored", d, 8'h00);

    bus_write(3'd1, 8'd3);
    ticks_to_ce(n);
    check("div3_first", n, 4);
    ticks_to_ce(n);
    check("div3_period", n, 4);
    bus_write(3'd1, 8'd0);
    ticks_to_ce(n);
    check("div0_first", n, 1);
    ticks_to_ce(n);
    check("div0_period", n, 1);

    bus_write(3'd3, 8'h05);
    bus_read(3'd3, d);
    check("rd_mask", d, 8'h05);
    irq_src = 8'h04;
    tick();
    check("edge_irq_n", cpu_irq_n, 0);
    irq_src = 8'h00;
    bus_read(3'd2, d);
    check("rd_pend", d, 8'h04);

    // clear and fresh edge in the same cycle: bit stays set
    wait_ce();
    irq_src   = 8'h04;
    bus_addr  = BASE | 16'd2;
    bus_wdata = 8'h04;
    bus_we    = 1'b1;
    bus_cyc   = 1'b1;
    tick();
    bus_cyc   = 1'b0;
    bus_we    = 1'b0;
    check("set_wins_irq_n", cpu_irq_n, 0);
    bus_read(3'd2, d);
    check("set_wins_pend", d, 8'h04);
    bus_write(3'd2, 8'h04);
    check("clr_irq_n", cpu_irq_n, 1);
    irq_src = 8'h02;
    tick();
    check("masked_irq_n", cpu_irq_n, 1);
    bus_read(3'd2, d);
    check("masked_pend", d, 8'h02);
    bus_write(3'd2, 8'h02);
    irq_src = 8'h00;
    tick();

    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h80);
    irq_src = 8'h80;
    tick();
`ifdef SYS_CTRL_NMI_EN
    check("nmi_nmi_n", cpu_nmi_n, 0);
    check("nmi_irq_n", cpu_irq_n, 1);
    bus_read(3'd4, d);
    check("rd_nmisel", d, 8'h80);
    bus_write(3'd3, 8'h80);
    check("nmi_mask_irq_n", cpu_irq_n, 1);
`else
    check("nmi_nmi_n", cpu_nmi_n, 1);
    check("nmi_irq_n", cpu_irq_n, 1);
    bus_read(3'd4, d);
    check("rd_nmisel", d, 8'h00);
    bus_write(3'd3, 8'h80);
    check("nmi_mask_irq_n", cpu_irq_n, 0);
`endif
    bus_write(3'd2, 8'h80);
    check("nmi_clr_nmi_n", cpu_nmi_n, 1);
    check("nmi_clr_irq_n", cpu_irq_n, 1);
    irq_src = 8'h00;
    bus_write(3'd3, 8'h00);

    check("run_cpu_reset", cpu_reset, 0);
    clk_locked = 1'b0;
    tick();
    check("lock_loss", cpu_reset, 1);
    tick();
    tick();
    clk_locked = 1'b1;
    repeat (15) tick();
    check("relock_15", cpu_reset, 1);
    tick();
    check("relock_16", cpu_reset, 0);

    bus_write(3'd0, 8'h00);
    check("rdy_low", cpu_rdy, 0);
    bus_write(3'd0, 8'h01);
    check("rdy_high", cpu_rdy, 1);

    bus_write(3'd0, 8'h03);
    check("srst_assert", cpu_reset, 1);
    check("srst_rdy", cpu_rdy, 1);
    repeat (15) tick();
    check("srst_15", cpu_reset, 1);
    tick();
    check("srst_16", cpu_reset, 0);
    bus_read(3'd0, d);
    check("rd_ctrl_srst", d, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Memory-mapped system controller for the Zed64 SoC.
- Generates the CPU clock-enable from a programmable divider.
- Sequences CPU reset against PLL lock and a software reset request.
- Aggregates up to eight interrupt sources into the CPU IRQ and NMI lines.
- Drives CPU RDY, replacing the fixed counter-bit CPU clock and hard-tied IRQ/NMI/RDY in the SoC top level.

## Interface
Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..8)
- ADDR_WIDTH, 16, CPU address bus width
- BASE_ADDR, 16'hFFE0, base of the 8-byte register window (low 3 bits zero)
- RST_STRETCH, 16, CPU reset hold length in clk cycles after release (≥2)
- DIV_RESET, 8'd1, divider value after reset

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- clk_locked  in  1  PLL lock status
- bus_addr  in  ADDR_WIDTH  CPU address
- bus_wdata  in  8  CPU write data
- bus_we  in  1  1 = write, 0 = read
- bus_cyc  in  1  valid bus cycle
- bus_hit  out  1  address falls in the register window (combinational)
- bus_rdata  out  8  registered read data
- irq_src  in  NUM_IRQ  level interrupt sources
- cpu_ce  out  1  one-cycle CPU clock-enable pulse
- cpu_reset  out  1  CPU reset, active-high
- cpu_irq_n  out  1  CPU IRQ, active-low
- cpu_nmi_n  out  1  CPU NMI, active-low
- cpu_rdy  out  1  CPU ready

## Operation
- Access condition: an access takes place when bus_cyc, bus_hit and cpu_ce are all 1. Register offset is bus_addr[2:0].
- Registers:
  - 0 CTRL: bit0 RUN (drives cpu_rdy, reset 1); bit1 SRST (write 1 requests CPU reset, reads 0)
  - 1 DIV: divider value
  - 2 PEND: read pending bits; write 1 to clear a bit
  - 3 MASK: IRQ enable mask, reset 0
  - 4 NMISEL: sources routed to NMI, reset 0
  - 5 ID: constant 8'h64, read-only
  - 6–7: read 0, writes ignored
- Unimplemented bits (index ≥ NUM_IRQ) read 0.
- Divider:
  - Counter runs 0..DIV. cpu_ce = 1 when counter == DIV, then counter wraps to 0.
  - DIV = 0 gives cpu_ce on every cycle.
  - A DIV write loads the new value and clears the counter on the next cycle.
- Reset sequencer, two states:
  - HOLD: cpu_reset = 1. Counter counts while clk_locked = 1. Move to RUN when count reaches RST_STRETCH−1.
  - RUN: cpu_reset = 0.
  - Return to HOLD with the counter cleared on any of: reset, clk_locked = 0, or an SRST write.
- Interrupts:
  - A rising edge of irq_src[i], sampled against a registered copy, sets PEND[i].
  - A write-1-to-clear and a new edge in the same cycle: set wins.
  - cpu_irq_n = ~|(PEND & MASK & ~NMISEL).
  - cpu_nmi_n = ~|(PEND & NMISEL). NMISEL sources are independent of MASK.
- Reads: bus_rdata latches the selected register on the access cycle and holds until the next read access. Writes leave bus_rdata unchanged.

## Timing
- Values while reset = 1 and on the first cycle after:
  - cpu_reset = 1, cpu_irq_n = 1, cpu_nmi_n = 1, cpu_rdy = 1
  - bus_rdata = 0, PEND = 0, divider counter = 0, DIV = DIV_RESET
  - cpu_ce = 0 during reset; the first pulse comes DIV_RESET+1 cycles after reset falls
- The divider keeps running during HOLD, so the CPU samples cpu_reset on its enables.
- Release: cpu_reset falls exactly RST_STRETCH cycles after reset = 0 and clk_locked = 1 have both held continuously.
- Read latency: bus_rdata is valid one cycle after the access cycle.
- Write latency: register takes effect one cycle after the access cycle. cpu_rdy follows a RUN write one cycle later.
- Interrupt latency: a source edge at cycle n sets PEND at n+1; the IRQ/NMI output goes low at n+1 (combinational from PEND).
- A PEND clear at cycle n releases the output at n+1.
- A lock loss during RUN asserts cpu_reset on the next cycle.

## Configuration
- SYS_CTRL_NMI_EN defined: NMISEL is implemented and cpu_nmi_n operates as specified.
- SYS_CTRL_NMI_EN undefined:
  - NMISEL reads 0 and writes are ignored.
  - cpu_nmi_n is tied to 1.
  - All PEND & MASK bits drive cpu_irq_n.

## Structure
- Package sys_ctrl_pkg holds:
  - register offset constants (REG_CTRL … REG_ID)
  - SYS_ID = 8'h64
  - reset-sequencer state encoding (ST_HOLD, ST_RUN)
- One sub-module, sys_ctrl_irq: edge detect, PEND/MASK/NMISEL registers and the IRQ/NMI reduction. Parameterised by NUM_IRQ.
- Divider, reset sequencer and bus decode stay in the top level.

## Test plan
- Reset with clk_locked = 1, RST_STRETCH = 16 → cpu_reset falls exactly 16 cycles after reset falls; cpu_ce pulses every 2 cycles.
- Write DIV = 3, then DIV = 0 → cpu_ce period becomes 4 cycles, then every cycle; counter restarts at 0 after each write.
- MASK = 8'h05, pulse irq_src[2] → PEND = 8'h04 and cpu_irq_n = 0 one cycle later. Write PEND = 8'h04 on the same cycle as a new irq_src[2] edge → bit stays set.
- NMISEL = 8'h80, raise irq_src[7] with MASK = 0 → cpu_nmi_n = 0, cpu_irq_n stays 1. Without SYS_CTRL_NMI_EN → cpu_nmi_n stays 1, cpu_irq_n stays 1.
- Drop clk_locked mid-RUN for 3 cycles → cpu_reset = 1 the next cycle, then held for RST_STRETCH cycles after lock returns. Write CTRL = 8'h02 → same reset sequence.
- Read offset 5 → bus_rdata = 8'h64 one cycle later. Read offset 6 → 8'h00. Access with cpu_ce = 0 → ignored.
